// File: rtl/fifo_uart_tx.sv
// UART 8N1 transmitter that pulls bytes from an external FIFO one at a time.
// TXD comes straight from a flop; its next value is derived only from internal state.
module fifo_uart_tx #(
  parameter int CLKS_PER_BIT = 868
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        Empty,
  input  logic [7:0]  fifo_data_out,
  output logic        RE_fifo,
  output logic        TXD,
  output logic        Busy,
  output logic [31:0] tx_count
);

  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] BAUD_LAST = CW'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_READ, S_LOAD, S_START, S_DATA, S_STOP
  } state_t;

  state_t        r_state, w_state_next;
  logic [CW-1:0] r_baud, w_baud_next;
  logic [2:0]    r_bit_idx, w_bit_idx_next;
  logic [7:0]    r_shift, w_shift_next;
  logic [31:0]   r_tx_count, w_tx_count_next;
  logic          r_txd, w_txd_next;
  logic          w_bit_end;

  always_comb begin
    w_state_next    = r_state;
    w_baud_next     = r_baud;
    w_bit_idx_next  = r_bit_idx;
    w_shift_next    = r_shift;
    w_tx_count_next = r_tx_count;
    w_txd_next      = 1'b1;
    w_bit_end       = (r_baud == BAUD_LAST);

    case (r_state)
      S_IDLE: if (!Empty) w_state_next = S_READ;
      S_READ: w_state_next = S_LOAD;
      S_LOAD: begin
        w_shift_next   = fifo_data_out;
        w_baud_next    = '0;
        w_bit_idx_next = '0;
        w_txd_next     = 1'b0;
        w_state_next   = S_START;
      end
      S_START: begin
        w_txd_next  = 1'b0;
        w_baud_next = w_bit_end ? '0 : r_baud + CW'(1);
        if (w_bit_end) begin
          w_txd_next   = r_shift[0];
          w_state_next = S_DATA;
        end
      end
      S_DATA: begin
        w_txd_next  = r_shift[0];
        w_baud_next = w_bit_end ? '0 : r_baud + CW'(1);
        if (w_bit_end) begin
          // next bit is r_shift[1]; the shift lands on the same edge
          w_shift_next   = {1'b0, r_shift[7:1]};
          w_bit_idx_next = r_bit_idx + 3'd1;
          w_txd_next     = r_shift[1];
          if (r_bit_idx == 3'd7) begin
            w_txd_next   = 1'b1;
            w_state_next = S_STOP;
          end
        end
      end
      S_STOP: begin
        w_baud_next = w_bit_end ? '0 : r_baud + CW'(1);
        if (w_bit_end) begin
          w_tx_count_next = r_tx_count + 32'd1;
          w_state_next    = S_IDLE;
        end
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state    <= S_IDLE;
      r_baud     <= '0;
      r_bit_idx  <= '0;
      r_shift    <= '0;
      r_tx_count <= '0;
      r_txd      <= 1'b1;
    end else begin
      r_state    <= w_state_next;
      r_baud     <= w_baud_next;
      r_bit_idx  <= w_bit_idx_next;
      r_shift    <= w_shift_next;
      r_tx_count <= w_tx_count_next;
      r_txd      <= w_txd_next;
    end
  end

  assign RE_fifo  = (r_state == S_READ);
  assign Busy     = (r_state != S_IDLE);
  assign TXD      = r_txd;
  assign tx_count = r_tx_count;

endmodule
